// File: rtl/fact_pkg.sv
// Shared constants and types for the factorial accelerator.
package fact_pkg;

  // Word addresses of the register window
  localparam logic [1:0] ADDR_N      = 2'd0;
  localparam logic [1:0] ADDR_GO     = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  // Largest operand whose factorial fits in 32 bits (12! = 479001600)
  localparam int unsigned MAX_N_DEF = 12;

  // STATUS bit positions
  localparam int unsigned DONE_BIT = 0;
  localparam int unsigned ERR_BIT  = 1;
  localparam int unsigned BUSY_BIT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/fact_cu.sv
// Control FSM for the factorial engine. The datapath strobes act on the
// same edge as the decision, so they are decoded from the current state.
module fact_cu
  import fact_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_n_gt_max,
  input  logic i_cnt_gt_1,
  output logic o_load,
  output logic o_dec_mul,
  output logic o_latch_result,
  output logic o_set_done,
  output logic o_set_err,
  output logic o_busy
);

  state_e r_state;

  // State register: IDLE -> BUSY on an accepted start, back when cnt reaches 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (i_start && !i_n_gt_max) r_state <= BUSY;
        BUSY: if (!i_cnt_gt_1) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Datapath strobes for the current edge
  always_comb begin
    o_load         = 1'b0;
    o_dec_mul      = 1'b0;
    o_latch_result = 1'b0;
    o_set_err      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          o_set_err = i_n_gt_max;
          o_load    = !i_n_gt_max;
        end
      end
      BUSY: begin
        o_dec_mul      = i_cnt_gt_1;
        o_latch_result = !i_cnt_gt_1;
      end
      default: ;
    endcase
    o_set_done = o_latch_result | o_set_err;
  end

  assign o_busy = (r_state == BUSY);

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: register window plus iterative
// multiply datapath, sequenced by fact_cu.
module fact_accel
  import fact_pkg::*;
#(
  parameter int unsigned MAX_N = MAX_N_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        done
);

  logic [3:0]  r_n;
  logic        r_go;
  logic [3:0]  r_cnt;
  logic [31:0] r_prod;
  logic [31:0] r_result;
  logic        r_done;
  logic        r_err;

  logic        w_start;
  logic        w_n_gt_max;
  logic        w_cnt_gt_1;
  logic [31:0] w_mul;
  logic        w_load;
  logic        w_dec_mul;
  logic        w_latch_result;
  logic        w_set_done;
  logic        w_set_err;
  logic        w_busy;
  logic        w_unused_wd;

  assign w_start     = we && (a == ADDR_GO) && wd[0];
  assign w_n_gt_max  = ({28'd0, r_n} > MAX_N);
  assign w_cnt_gt_1  = (r_cnt > 4'd1);
  // 32x4 product, truncated; cannot overflow for accepted operands
  assign w_mul       = r_prod * {28'd0, r_cnt};
  assign w_unused_wd = ^wd[31:4];

  fact_cu u_cu (
    .clk            (clk),
    .reset          (reset),
    .i_start        (w_start),
    .i_n_gt_max     (w_n_gt_max),
    .i_cnt_gt_1     (w_cnt_gt_1),
    .o_load         (w_load),
    .o_dec_mul      (w_dec_mul),
    .o_latch_result (w_latch_result),
    .o_set_done     (w_set_done),
    .o_set_err      (w_set_err),
    .o_busy         (w_busy)
  );

  // Software-writable registers; STATUS and RESULT ignore writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n  <= 4'd0;
      r_go <= 1'b0;
    end else if (we) begin
      unique case (a)
        ADDR_N:  r_n  <= wd[3:0];
        ADDR_GO: r_go <= wd[0];
        default: ;
      endcase
    end
  end

  // Engine datapath: operand load, multiply-down loop, result and flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 4'd0;
      r_prod   <= 32'd0;
      r_result <= 32'd0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_load) begin
        r_cnt  <= r_n;
        r_prod <= 32'd1;
        r_err  <= 1'b0;
        r_done <= 1'b0;
      end
      if (w_dec_mul) begin
        r_prod <= w_mul;
        r_cnt  <= r_cnt - 4'd1;
      end
      if (w_latch_result) r_result <= r_prod;
      if (w_set_err) begin
        r_err    <= 1'b1;
        r_result <= 32'd0;
      end
      if (w_set_done) r_done <= 1'b1;
    end
  end

  // Read word select
  always_comb begin
    rd = 32'd0;
    unique case (a)
      ADDR_N:      rd = {28'd0, r_n};
      ADDR_GO:     rd = {31'd0, r_go};
      ADDR_STATUS: begin
        rd[BUSY_BIT] = w_busy;
        rd[ERR_BIT]  = r_err;
        rd[DONE_BIT] = r_done;
      end
      ADDR_RESULT: rd = r_result;
      default:     rd = 32'd0;
    endcase
  end

  assign done = r_done;

endmodule

// File: tb/tb_fact_accel.sv
// Self-checking bench for fact_accel: directed steps plus random operands
// checked against a plain-arithmetic factorial model.
module tb_fact_accel;

  localparam logic [1:0] A_N = 2'd0;
  localparam logic [1:0] A_GO = 2'd1;
  localparam logic [1:0] A_ST = 2'd2;
  localparam logic [1:0] A_RES = 2'd3;
  localparam int MAXN = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [1:0]  a = 2'd0;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic        done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fact_accel dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .done  (done)
  );

  function automatic logic [31:0] fact_ref(input int n);
    int unsigned p = 1;
    for (int i = 2; i <= n; i++) p = p * i;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    chk(tag, rd, exp);
  endtask

  // One bus write, completing on the next rising edge
  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1;
    a  = addr;
    wd = data;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  // Issue GO with the current N (n) and follow the run edge by edge
  task automatic go_and_check(input int n, input string tag);
    int lat;
    wr(A_GO, 32'd1);
    if (n > MAXN) begin
      rd_chk({tag, " err status"}, A_ST, 32'd3);
      rd_chk({tag, " err result"}, A_RES, 32'd0);
      chk({tag, " err done"}, {31'd0, done}, 32'd1);
      @(posedge clk);
      #1;
      rd_chk({tag, " err no busy"}, A_ST, 32'd3);
    end else begin
      lat = (n < 1) ? 1 : n;
      rd_chk({tag, " busy"}, A_ST, 32'd4);
      for (int i = 1; i < lat; i++) begin
        @(posedge clk);
        #1;
        rd_chk({tag, " still busy"}, A_ST, 32'd4);
      end
      @(posedge clk);
      #1;
      rd_chk({tag, " status"}, A_ST, 32'd1);
      rd_chk({tag, " result"}, A_RES, fact_ref(n));
      chk({tag, " done"}, {31'd0, done}, 32'd1);
    end
  endtask

  task automatic run(input int n, input string tag);
    wr(A_N, n);
    go_and_check(n, tag);
  endtask

  initial begin
    logic [31:0] r;
    int n;

    // Reset state
    #2;
    rd_chk("rst N", A_N, 32'd0);
    rd_chk("rst GO", A_GO, 32'd0);
    rd_chk("rst STATUS", A_ST, 32'd0);
    rd_chk("rst RESULT", A_RES, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run(5, "n5");
    run(0, "n0");
    run(1, "n1");
    run(12, "n12");
    rd_chk("n12 const", A_RES, 32'h1C8CFC00);
    run(13, "n13");

    // Writes to STATUS/RESULT are ignored
    wr(A_RES, 32'hDEAD_BEEF);
    wr(A_ST, 32'hFFFF_FFFF);
    rd_chk("ro result", A_RES, 32'd0);
    rd_chk("ro status", A_ST, 32'd3);

    // N and GO writes during a run do not disturb it
    wr(A_N, 32'd7);
    wr(A_GO, 32'd1);
    wr(A_N, 32'd3);
    wr(A_GO, 32'd1);
    rd_chk("mid N", A_N, 32'd3);
    rd_chk("mid GO", A_GO, 32'd1);
    rd_chk("mid busy", A_ST, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    rd_chk("n7 not yet", A_ST, 32'd4);
    @(posedge clk);
    #1;
    rd_chk("n7 status", A_ST, 32'd1);
    rd_chk("n7 result", A_RES, 32'd5040);
    go_and_check(3, "n3 after");

    // Asynchronous reset in the middle of a run
    wr(A_N, 32'd9);
    wr(A_GO, 32'd1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    rd_chk("abort N", A_N, 32'd0);
    rd_chk("abort GO", A_GO, 32'd0);
    rd_chk("abort STATUS", A_ST, 32'd0);
    rd_chk("abort RESULT", A_RES, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run(4, "n4 after rst");

    // Random operands, junk in the upper write-data bits
    for (int k = 0; k < 24; k++) begin
      n = $urandom_range(0, 15);
      r = $urandom();
      r[3:0] = n[3:0];
      wr(A_N, r);
      rd_chk("rand N", A_N, n);
      go_and_check(n, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fact_accel.md
Name: fact_accel

Overview:
- Memory-mapped factorial accelerator on the SoC bus.
- Holds the operand, go, status and result registers and runs an iterative multiply engine.
- Presents a 4-word register window; the read path is a 4-way word select driven by the 2-bit word address.
- The SoC address decoder drives its write enable; its read data feeds the SoC read-data mux.

Parameters:
- MAX_N, 12, largest accepted operand; 12! = 479001600 is the largest factorial that fits in 32 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- we  input  1  write strobe for this block, already qualified by the address decoder.
- a  input  2  word address: 0=N, 1=GO, 2=STATUS, 3=RESULT.
- wd  input  32  write data.
- rd  output  32  read data; combinational from `a` and register state.
- done  output  1  copy of STATUS.done, for polling or an interrupt line.

Behaviour:
- Reset, asynchronous, takes effect immediately, including mid-operation:
  - n_reg=0, go_reg=0, cnt=0, prod=0, result=0, done=0, err=0, state=IDLE.
  - An aborted computation leaves no partial result visible.
- Register map, read values:
  - N: {28'b0, n_reg[3:0]}.
  - GO: {31'b0, go_reg}.
  - STATUS: {29'b0, busy, err, done}, where busy = (state==BUSY).
  - RESULT: result[31:0].
- Writes (on a clk edge with we=1):
  - N: n_reg<=wd[3:0]. Accepted in any state; a write during BUSY does not affect the running computation.
  - GO: go_reg<=wd[0].
  - STATUS, RESULT: read-only; writes are ignored.
- Start condition: write to GO with wd[0]=1 while state==IDLE, on that same edge:
  - If n_reg > MAX_N: err<=1, done<=1, result<=0; state stays IDLE.
  - Else: cnt<=n_reg, prod<=1, err<=0, done<=0, state<=BUSY.
  - The operand sampled is n_reg as held before the edge. A same-cycle N write is impossible because there is a single write port.
- A GO=1 write while BUSY updates go_reg only; it does not restart the engine.
- FSM states: IDLE, BUSY.
- BUSY, each edge:
  - If cnt > 1: prod<=prod*cnt (32x4 multiply, truncated to 32 bits; no overflow is possible for n<=12), cnt<=cnt-1.
  - Else: result<=prod, done<=1, state<=IDLE.
- Latency: done rises max(n,1) edges after the GO edge.
  - n=5: 5 edges.
  - n=0 or n=1: 1 edge, result=1.
- done and err stay set until the next accepted start or reset.
- go_reg is a plain software-visible bit. Clearing it has no effect on a running computation.

Decomposition:
- Shared package fact_pkg:
  - Word-address constants ADDR_N=0, ADDR_GO=1, ADDR_STATUS=2, ADDR_RESULT=3.
  - State encoding IDLE=1'b0, BUSY=1'b1.
  - MAX_N default.
  - STATUS bit positions DONE_BIT=0, ERR_BIT=1, BUSY_BIT=2.
- One sub-module: fact_cu, the control FSM.
  - Inputs: start strobe, n_gt_max, cnt_gt_1.
  - Outputs: load, dec_mul, latch_result, set_done, set_err.
  - The datapath (cnt, prod, result, multiplier, compare) and the register/read logic stay in fact_accel.

Test Plan:
- Reset then read all four addresses -> rd=0 for each; done=0.
- Write N=5, write GO=1 -> busy=1 for 5 edges, then STATUS=3'b001, RESULT=120, done=1.
- N=0 and, separately, N=1 -> done after 1 edge, RESULT=1, err=0.
- N=12 -> RESULT=479001600 (0x1C8CFC00) after 12 edges. N=13 -> same edge STATUS=3'b011, RESULT=0, busy never set.
- During an N=7 run, write N=3 and GO=1 at edge 2 -> run unaffected, RESULT=5040. A subsequent GO then gives 6.
- Assert reset at edge 3 of an N=9 run -> all outputs 0 immediately. A following GO with N=4 gives RESULT=24.
